// File: rtl/mod_memstage_pkg.sv
// Shared types for the memory-access stage:
// pipeline bundles, memop encodings, FSM states.
package mod_memstage_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [63:0] imm;
    logic [7:0]  opcode;
    logic        twob;
    logic [7:0]  reg_byte;
    logic [7:0]  rm_byte;
    logic        dep;
    logic        sim_end;
  } mem_ex_t;

  typedef struct packed {
    logic        zf;
    logic        sf;
    logic        of;
  } flags_reg_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [7:0]  opcode;
    flags_reg_t  flags;
    logic        sim_end;
  } ex_wb_t;

  localparam logic [1:0] MEMOP_NONE  = 2'd0;
  localparam logic [1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [1:0] MEMOP_STORE = 2'd2;
  localparam logic [1:0] MEMOP_RSVD  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

endpackage

// File: rtl/mod_memstage_if.sv
// Single-outstanding memory port between the
// memory stage (master) and the memory (slave).
interface mod_memstage_if #(
  parameter int ADDR_W = 64
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mod_mem_align.sv
// Byte-lane steering for split 8-byte accesses:
// store strobes/data per beat and load merge.
module mod_mem_align (
  input  logic [2:0]  off,
  input  logic        beat,
  input  logic [63:0] sdata,
  input  logic [63:0] rdata,
  input  logic [63:0] lbuf,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic [63:0] merged
);
  logic [5:0]  sh;
  logic [6:0]  inv;
  logic [3:0]  binv;
  logic [63:0] keep;

  assign sh   = {off, 3'b000};
  assign inv  = 7'd64 - {1'b0, sh};
  assign binv = 4'd8 - {1'b0, off};
  assign keep = {64{1'b1}} >> sh;

  // beat1 fills the top off bytes; low bytes stay from beat0
  always_comb begin
    wstrb  = 8'hFF << off;
    wdata  = sdata << sh;
    merged = rdata >> sh;
    if (beat) begin
      wstrb  = 8'hFF >> binv;
      wdata  = sdata >> inv;
      merged = (lbuf & keep) | (rdata << inv);
    end
  end
endmodule

// File: rtl/mod_memstage.sv
// Memory-access stage: 8-byte loads/stores over a
// single-outstanding port, unaligned split in two beats.
module mod_memstage
  import mod_memstage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_memop,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_sdata,
  input  mem_ex_t           in_memex,
  input  logic              flush,
  mod_memstage_if.master    bus,
  output logic              can_execute,
  input  logic              ex_ready,
  output mem_ex_t           memex,
  output logic [DATA_W-1:0] load_buffer,
  output logic              loadbuffer_done,
  output logic              memstage_active,
  output logic              store_memstage_active
);
  logic [2:0]        state;
  logic [2:0]        off;
  logic [ADDR_W-4:0] base;
  logic              split;
  logic              ld;
  logic              st;
  logic              fl;
  logic [DATA_W-1:0] sdata;

  logic        accept;
  logic        is_mem;
  logic        beat;
  logic        in_req;
  logic [2:0]  fin;
  logic [7:0]  wstrb;
  logic [63:0] wdata;
  logic [63:0] merged;

  assign in_req = (state == S_REQ0)
                | (state == S_REQ1);
  assign beat   = (state == S_REQ1)
                | (state == S_WAIT1);
  assign is_mem = (in_memop == MEMOP_LOAD)
                | (in_memop == MEMOP_STORE);

  assign in_ready = reset & ~flush &
    ((state == S_IDLE) |
     ((state == S_OUT) & ex_ready));
  assign accept = in_valid & in_ready;

  // a flushed op still finishes its bus beats, then vanishes
  assign fin = (fl | flush) ? S_IDLE : S_OUT;

  mod_mem_align u_align (
    .off    (off),
    .beat   (beat),
    .sdata  (sdata),
    .rdata  (bus.mem_rdata),
    .lbuf   (load_buffer),
    .wstrb  (wstrb),
    .wdata  (wdata),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      off         <= '0;
      base        <= '0;
      split       <= 1'b0;
      ld          <= 1'b0;
      st          <= 1'b0;
      fl          <= 1'b0;
      sdata       <= '0;
      memex       <= '0;
      load_buffer <= '0;
    end else if (accept) begin
      off   <= in_addr[2:0];
      base  <= in_addr[ADDR_W-1:3];
      split <= (in_addr[2:0] != 3'd0);
      ld    <= (in_memop == MEMOP_LOAD);
      st    <= (in_memop == MEMOP_STORE);
      fl    <= 1'b0;
      sdata <= in_sdata;
      memex <= in_memex;
      state <= is_mem ? S_REQ0 : S_OUT;
    end else begin
      case (state)
        S_REQ0:
          if (bus.mem_gnt) begin
            fl <= fl | flush;
            if (!st)
              state <= S_WAIT0;
            else if (split)
              state <= S_REQ1;
            else
              state <= fin;
          end else if (flush) begin
            state <= S_IDLE;
          end
        S_WAIT0: begin
          fl <= fl | flush;
          if (bus.mem_rvalid) begin
            load_buffer <= merged;
            state <= split ? S_REQ1 : fin;
          end
        end
        S_REQ1: begin
          fl <= fl | flush;
          if (bus.mem_gnt)
            state <= st ? fin : S_WAIT1;
        end
        S_WAIT1: begin
          fl <= fl | flush;
          if (bus.mem_rvalid) begin
            load_buffer <= merged;
            state <= fin;
          end
        end
        S_OUT:
          if (flush || ex_ready)
            state <= S_IDLE;
        S_IDLE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & st;
  assign bus.mem_addr  = !in_req ? '0 :
    beat ? {base + 1'b1, 3'b000}
         : {base, 3'b000};
  assign bus.mem_wstrb = bus.mem_we ? wstrb : '0;
  assign bus.mem_wdata = bus.mem_we ? wdata : '0;

  assign can_execute     = (state == S_OUT);
  assign loadbuffer_done = can_execute & ld;
  assign memstage_active = (state != S_IDLE);
  assign store_memstage_active = st &
    (state inside {S_REQ0, S_WAIT0, S_REQ1, S_WAIT1});
endmodule
